stopwatch_counter: RTL and testbench

//  Stopwatch time base feeding final_display. Counts MM:SS on 1 Hz tick pulses, supports

---
 rtl/stopwatch_counter.sv | 147 ++++++++++++++
 tb/tb_stopwatch_counter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS stopwatch time base with pause and per-field adjust.
// Counters are packed BCD and visible live; the four 7-seg patterns are registered.
// Optional feature macro: STOPWATCH_LAP_EN (lap hold of the displayed value).
module stopwatch_counter #(
    parameter int MIN_MAX = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_hz_en,
    input  logic       two_hz_en,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       select,
    input  logic       lap_p,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [6:0] vec3,
    output logic [6:0] vec2,
    output logic [6:0] vec1,
    output logic [6:0] vec0
);

    localparam logic [6:0] SEG_ZERO = 7'b1000000;

    logic        paused_q, paused_d;
    logic [7:0]  min_q, min_d;
    logic [7:0]  sec_q, sec_d;
    logic [27:0] vec_q, vec_d;
    logic [15:0] disp;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Seconds wrap 59 -> 00; the caller decides whether that carries.
    function automatic logic [7:0] sec_inc(input logic [7:0] s);
        if (s[3:0] >= 4'd9) begin
            if (s[7:4] >= 4'd5) sec_inc = 8'h00;
            else                sec_inc = {s[7:4] + 4'd1, 4'd0};
        end else begin
            sec_inc = {s[7:4], s[3:0] + 4'd1};
        end
    endfunction

    // Minutes wrap at MIN_MAX, compared in binary so any legal limit works.
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        logic [7:0] bin;
        bin = 8'(m[7:4]) * 8'd10 + 8'(m[3:0]);
        if (bin >= 8'(MIN_MAX))  min_inc = 8'h00;
        else if (m[3:0] >= 4'd9) min_inc = {m[7:4] + 4'd1, 4'd0};
        else                     min_inc = {m[7:4], m[3:0] + 4'd1};
    endfunction

    // Next counter state: adjust beats pause beats run; ticks see the pre-toggle pause flag.
    always_comb begin
        min_d    = min_q;
        sec_d    = sec_q;
        paused_d = paused_q ^ pause_p;
        if (adj) begin
            if (two_hz_en) begin
                if (select) sec_d = sec_inc(sec_q);
                else        min_d = min_inc(min_q);
            end
        end else if (!paused_q && one_hz_en) begin
            sec_d = sec_inc(sec_q);
            if (sec_q == 8'h59) min_d = min_inc(min_q);
        end
    end

    // Counter and pause state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q    <= 8'h00;
            sec_q    <= 8'h00;
            paused_q <= 1'b0;
        end else begin
            min_q    <= min_d;
            sec_q    <= sec_d;
            paused_q <= paused_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_q, lap_d;
    logic [15:0] hold_q, hold_d;

    // Lap toggles outside adjust; setting it freezes the current time in the hold register.
    always_comb begin
        lap_d  = lap_q;
        hold_d = hold_q;
        if (lap_p && !adj) begin
            lap_d = !lap_q;
            if (!lap_q) hold_d = {min_q, sec_q};
        end
    end

    // Lap flag and held time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q  <= 1'b0;
            hold_q <= 16'h0000;
        end else begin
            lap_q  <= lap_d;
            hold_q <= hold_d;
        end
    end

    // Using the next lap state makes the display switch on the edge that takes the pulse.
    assign disp = (lap_d && !adj) ? hold_d : {min_q, sec_q};
`else
    logic unused_lap;
    assign unused_lap = lap_p;
    assign disp       = {min_q, sec_q};
`endif

    // Registered segment encode of the display source.
    always_comb begin
        vec_d = {seg7(disp[15:12]), seg7(disp[11:8]), seg7(disp[7:4]), seg7(disp[3:0])};
    end

    // Segment output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vec_q <= {4{SEG_ZERO}};
        else     vec_q <= vec_d;
    end

    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
    assign vec3    = vec_q[27:21];
    assign vec2    = vec_q[20:14];
    assign vec1    = vec_q[13:7];
    assign vec0    = vec_q[6:0];

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench for stopwatch_counter: directed scenarios plus a randomized
// run against a time-in-seconds reference model.
module tb_stopwatch_counter;

    localparam int MAXM = 99;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       one_hz_en = 1'b0, two_hz_en = 1'b0, pause_p = 1'b0;
    logic       adj = 1'b0, select = 1'b0, lap_p = 1'b0;
    logic [7:0] min_bcd, sec_bcd;
    logic [6:0] vec3, vec2, vec1, vec0;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_min, m_sec, m_hmin, m_hsec;
    bit          m_paused, m_lap;
    logic [27:0] m_vec;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    stopwatch_counter #(.MIN_MAX(MAXM)) dut (
        .clk(clk), .rst(rst), .one_hz_en(one_hz_en), .two_hz_en(two_hz_en),
        .pause_p(pause_p), .adj(adj), .select(select), .lap_p(lap_p),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .vec3(vec3), .vec2(vec2), .vec1(vec1), .vec0(vec0)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic [27:0] enc(input int mn, input int sc);
        return {seg_tab[mn / 10], seg_tab[mn % 10], seg_tab[sc / 10], seg_tab[sc % 10]};
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_paused = 0; m_lap = 0; m_hmin = 0; m_hsec = 0;
        m_vec = enc(0, 0);
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int pm, ps, tot;
        bit show_hold;
        pm = m_min; ps = m_sec;
        if (adj) begin
            if (two_hz_en) begin
                if (select) m_sec = (m_sec + 1) % 60;
                else        m_min = (m_min >= MAXM) ? 0 : m_min + 1;
            end
        end else if (!m_paused && one_hz_en) begin
            tot   = (m_min * 60 + m_sec + 1) % ((MAXM + 1) * 60);
            m_min = tot / 60;
            m_sec = tot % 60;
        end
        if (pause_p) m_paused = !m_paused;
`ifdef STOPWATCH_LAP_EN
        if (lap_p && !adj) begin
            if (!m_lap) begin m_hmin = pm; m_hsec = ps; end
            m_lap = !m_lap;
        end
        show_hold = m_lap && !adj;
`else
        show_hold = 1'b0;
`endif
        m_vec = show_hold ? enc(m_hmin, m_hsec) : enc(pm, ps);
    endtask

    // One clock with the given pulses and levels; pulses drop after the edge.
    task automatic tick(input bit o, input bit t, input bit p, input bit a, input bit s, input bit l);
        one_hz_en = o; two_hz_en = t; pause_p = p; adj = a; select = s; lap_p = l;
        @(posedge clk);
        model_step();
        #1;
        one_hz_en = 0; two_hz_en = 0; pause_p = 0; lap_p = 0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // From 00:00, walk the fields to mn:sc with adjust pulses, then leave adjust.
    task automatic preset(input int mn, input int sc);
        for (int i = 0; i < mn; i++) tick(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < sc; i++) tick(0, 1, 0, 1, 1, 0);
        tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        preset(12, 34);
        checks++;
        if (min_bcd !== 8'h12 || sec_bcd !== 8'h34) begin
            errors++; $display("FAIL preset_12_34: got %h:%h want 12:34", min_bcd, sec_bcd);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (min_bcd !== 8'h00 || sec_bcd !== 8'h00) begin
            errors++; $display("FAIL reset_async_bcd: got %h:%h want 00:00", min_bcd, sec_bcd);
        end
        @(posedge clk); #1;
        checks++;
        if ({vec3, vec2, vec1, vec0} !== enc(0, 0)) begin
            errors++; $display("FAIL reset_vec: got %h want %h", {vec3, vec2, vec1, vec0}, enc(0, 0));
        end
        rst = 1'b0;
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (sec_bcd !== 8'h01 || min_bcd !== 8'h00) begin
            errors++; $display("FAIL reset_first_tick: got %h:%h want 00:01", min_bcd, sec_bcd);
        end
    endtask

    task automatic test_rollover();
        logic [7:0] want_s [3] = '{8'h59, 8'h00, 8'h01};
        logic [7:0] want_m [3] = '{8'h00, 8'h01, 8'h01};
        do_reset();
        preset(0, 58);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            checks++;
            if (min_bcd !== want_m[i] || sec_bcd !== want_s[i]) begin
                errors++;
                $display("FAIL rollover_%0d: got %h:%h want %h:%h", i, min_bcd, sec_bcd, want_m[i], want_s[i]);
            end
            if (i == 1) begin
                tick(0, 0, 0, 0, 0, 0);
                checks++;
                if (vec1 !== 7'b1000000 || vec2 !== 7'b1111001) begin
                    errors++; $display("FAIL rollover_vec: got vec2=%b vec1=%b want 1111001 1000000", vec2, vec1);
                end
            end
        end
    endtask

    task automatic test_minmax();
        do_reset();
        preset(MAXM, 59);
        checks++;
        if (min_bcd !== bcd(MAXM) || sec_bcd !== 8'h59) begin
            errors++; $display("FAIL minmax_preset: got %h:%h want %h:59", min_bcd, sec_bcd, bcd(MAXM));
        end
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (min_bcd !== 8'h00 || sec_bcd !== 8'h00) begin
            errors++; $display("FAIL minmax_wrap: got %h:%h want 00:00", min_bcd, sec_bcd);
        end
        preset(MAXM, 0);
        tick(0, 1, 0, 1, 0, 0);
        checks++;
        if (min_bcd !== 8'h00) begin
            errors++; $display("FAIL minmax_adj_wrap: got %h want 00", min_bcd);
        end
    endtask

    task automatic test_adjust_sec();
        logic [7:0] want_s [3] = '{8'h59, 8'h00, 8'h01};
        do_reset();
        preset(5, 58);
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 1, 1, 0);
            tick(0, 1, 0, 1, 1, 0);
            checks++;
            if (min_bcd !== 8'h05 || sec_bcd !== want_s[i]) begin
                errors++;
                $display("FAIL adjust_sec_%0d: got %h:%h want 05:%h", i, min_bcd, sec_bcd, want_s[i]);
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        preset(0, 10);
        tick(1, 0, 1, 0, 0, 0);
        checks++;
        if (sec_bcd !== 8'h11) begin
            errors++; $display("FAIL pause_coincident: got %h want 11", sec_bcd);
        end
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (sec_bcd !== 8'h11 || min_bcd !== 8'h00) begin
            errors++; $display("FAIL pause_hold: got %h:%h want 00:11", min_bcd, sec_bcd);
        end
        // paused flag must survive a trip through adjust
        tick(0, 1, 0, 1, 1, 0);
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (sec_bcd !== 8'h12) begin
            errors++; $display("FAIL pause_through_adj: got %h want 12", sec_bcd);
        end
        tick(0, 0, 1, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (sec_bcd !== 8'h13) begin
            errors++; $display("FAIL pause_resume: got %h want 13", sec_bcd);
        end
    endtask

`ifdef STOPWATCH_LAP_EN
    task automatic test_lap();
        do_reset();
        preset(0, 20);
        tick(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (sec_bcd !== 8'h24 || {vec3, vec2, vec1, vec0} !== enc(0, 20)) begin
            errors++; $display("FAIL lap_hold: got sec %h vec %h want 24 %h", sec_bcd, {vec3, vec2, vec1, vec0}, enc(0, 20));
        end
        tick(0, 0, 0, 0, 0, 1);
        checks++;
        if ({vec3, vec2, vec1, vec0} !== enc(0, 24)) begin
            errors++; $display("FAIL lap_release: got %h want %h", {vec3, vec2, vec1, vec0}, enc(0, 24));
        end
    endtask
`endif

    task automatic test_random();
        bit a, s;
        do_reset();
        preset(98, 30);
        a = 0; s = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(15) == 0) a = !a;
            if ($urandom_range(7) == 0)  s = !s;
            tick($urandom_range(3) == 0, $urandom_range(3) == 0, $urandom_range(11) == 0,
                 a, s, $urandom_range(9) == 0);
            checks++;
            if (min_bcd !== bcd(m_min) || sec_bcd !== bcd(m_sec)) begin
                errors++;
                $display("FAIL rand_bcd_%0d: got %h:%h want %h:%h", i, min_bcd, sec_bcd, bcd(m_min), bcd(m_sec));
            end
            checks++;
            if ({vec3, vec2, vec1, vec0} !== m_vec) begin
                errors++; $display("FAIL rand_vec_%0d: got %h want %h", i, {vec3, vec2, vec1, vec0}, m_vec);
            end
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (min_bcd !== 8'h00 || sec_bcd !== 8'h00 || {vec3, vec2, vec1, vec0} !== enc(0, 0)) begin
            errors++; $display("FAIL power_on_reset: got %h:%h vec %h", min_bcd, sec_bcd, {vec3, vec2, vec1, vec0});
        end
        rst = 1'b0;
        test_reset();
        test_rollover();
        test_minmax();
        test_adjust_sec();
        test_pause();
`ifdef STOPWATCH_LAP_EN
        test_lap();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
